main_top: RTL and testbench
===========================

MAIN_TOP -- requirements
Module: main_top

Interface
REQ-001 Parameter DATA_W, default 16, data word width.
REQ-002 Parameter MAX_N, default 8, largest supported square-matrix dimension.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 com_data_in  input  16  load-stream word.
REQ-006 data_write_start  input  1  host is streaming input words.
REQ-007 data_write_done  input  1  host has finished streaming.
REQ-008 state  output  2  current FSM state.
REQ-009 com_data_out  output  16  result-stream word.
REQ-010 output_write_start  output  1  result stream is valid this cycle.
REQ-011 output_write_done  output  1  current com_data_out is the final result word.

Function
REQ-012 The block SHALL compute C = A x B for N x N matrices of 16-bit unsigned words, using two parallel compute cores.
REQ-013 The FSM SHALL encode its states as IDLE=2'b00, LOAD=2'b01, COMPUTE=2'b10 and OUTPUT=2'b11, and SHALL drive the current encoding on state.
REQ-014 IDLE SHALL go to LOAD on any cycle with data_write_start=1.
REQ-015 LOAD SHALL capture com_data_in on every cycle with data_write_start=1 and data_write_done=0: word 0 is N (bits[3:0]), words 1..N*N are A row-major, and the next N*N words are B row-major.
REQ-016 LOAD SHALL ignore words beyond index 2*N*N.
REQ-017 LOAD SHALL go to COMPUTE on the first cycle with data_write_done=1; the word on that cycle SHALL NOT be captured.
REQ-018 Any A or B element not captured before data_write_done SHALL read as 0 during COMPUTE.
REQ-019 Core 0 SHALL compute the even rows of C and core 1 the odd rows, each performing one multiply-accumulate per cycle.
REQ-020 Products and sums SHALL be truncated modulo 2^16.
REQ-021 COMPUTE SHALL finish within N*N*ceil(N/2)+4 cycles and then go to OUTPUT.
REQ-022 OUTPUT SHALL present one C element per cycle in row-major order on com_data_out, with output_write_start=1 on each of those N*N cycles.
REQ-023 output_write_done SHALL be 1 only during the cycle that presents C[N-1][N-1].
REQ-024 On the cycle after the final word, the FSM SHALL return to IDLE and output_write_start, output_write_done and com_data_out SHALL be 0.
REQ-025 If N=0 or N>MAX_N: LOAD SHALL capture no further words, COMPUTE SHALL be skipped, and OUTPUT SHALL emit a single word 16'hFFFF with output_write_start=1 and output_write_done=1.
REQ-026 data_write_start and data_write_done SHALL be ignored outside IDLE and LOAD.
REQ-027 If data_write_done=1 arrives in LOAD before word 0, the block SHALL treat N as 0 and apply REQ-025.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 With rst_n=0 at a rising edge, the block SHALL set state=IDLE, com_data_out=0, output_write_start=0, output_write_done=0, and clear the load counter, N and the core accumulators.
REQ-030 Reset SHALL NOT clear matrix storage; the loaded-count gating of REQ-018 SHALL prevent use of stale data.
REQ-031 Reset SHALL take effect in any state, including mid-COMPUTE and mid-OUTPUT, and SHALL abort the operation without emitting further words.

Verification
REQ-032 Load N=2, A=1,2,3,4, B=5,6,7,8, then done -> output stream 19,22,43,50; done=1 only on 50; state returns to 00.
REQ-033 Load N=1, A=300, B=300 -> single output word 24464 (90000 mod 65536) with start=1 and done=1.
REQ-034 Load N=0 -> single output word 16'hFFFF with start=1 and done=1; no COMPUTE state observed.
REQ-035 Load N=2 and A only, then done -> output stream 0,0,0,0.
REQ-036 Assert rst_n=0 for one cycle mid-COMPUTE -> next cycle state=00 and all outputs 0; a subsequent N=2 reload reproduces REQ-032.
REQ-037 Load N=8 with A=identity and B elements = index 0..63 -> output 0..63 in order, completing within 260 cycles of data_write_done.

Source files
------------

// File: rtl/main_top.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | main_top : streamed N x N matrix multiply (C = A x B), two MAC cores      |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module main_top #(
  parameter int DATA_W = 16,
  parameter int MAX_N  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] com_data_in,
  input  logic              data_write_start,
  input  logic              data_write_done,
  output logic [1:0]        state,
  output logic [DATA_W-1:0] com_data_out,
  output logic              output_write_start,
  output logic              output_write_done
);

  localparam int         c_AW    = (MAX_N * MAX_N > 1) ? $clog2(MAX_N * MAX_N) : 1;
  localparam int         c_DEPTH = 1 << c_AW;
  localparam logic [4:0] c_MAX_N = 5'(MAX_N);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    LOAD    = 2'b01,
    COMPUTE = 2'b10,
    OUTPUT  = 2'b11
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_mem_a [c_DEPTH];
  logic [DATA_W-1:0] r_mem_b [c_DEPTH];
  logic [DATA_W-1:0] r_mem_c [c_DEPTH];
  logic [8:0]        r_cnt;
  logic [3:0]        r_n;
  logic              r_err;
  logic              r_drain;
  logic [4:0]        r_row;
  logic [3:0]        r_col;
  logic [3:0]        r_k;
  logic [7:0]        r_oidx;
  logic [DATA_W-1:0] r_acc [2];
  logic [DATA_W-1:0] r_dout;
  logic              r_ostart;
  logic              r_odone;

  logic [7:0]        w_nn;
  logic              w_n_ok;
  logic              w_capture;
  logic              w_first;
  logic              w_ld_we;
  logic              w_ld_a;
  logic [7:0]        w_b_addr;
  logic [DATA_W-1:0] w_b;
  logic              w_last_k;
  logic              w_last_col;
  logic              w_last_row;
  logic              w_c_we;
  logic [7:0]        w_base   [2];
  logic [DATA_W-1:0] w_a      [2];
  logic [DATA_W-1:0] w_sum    [2];
  logic              w_row_ok [2];

  assign w_nn      = 8'(r_n) * 8'(r_n);
  assign w_n_ok    = (r_n != 4'd0) && ({1'b0, r_n} <= c_MAX_N);
  assign w_capture = (r_state == LOAD) && data_write_start && !data_write_done;
  assign w_first   = w_capture && (r_cnt == 9'd0);
  // Word index r_cnt: 1..NN fill A, NN+1..2NN fill B, anything later is dropped.
  assign w_ld_we   = w_capture && (r_cnt != 9'd0) && w_n_ok && (r_cnt <= {w_nn, 1'b0});
  assign w_ld_a    = (r_cnt <= {1'b0, w_nn});

  // Operands never loaded read as zero, so stale storage is harmless.
  assign w_b_addr = 8'(r_k) * 8'(r_n) + 8'(r_col);
  assign w_b      = ({1'b0, w_nn} + {1'b0, w_b_addr} + 9'd1 < r_cnt) ?
                    r_mem_b[c_AW'(w_b_addr)] : '0;

  assign w_last_k   = (r_k == r_n - 4'd1);
  assign w_last_col = (r_col == r_n - 4'd1);
  assign w_last_row = (r_row + 5'd2 >= {1'b0, r_n});
  assign w_c_we     = (r_state == COMPUTE) && !r_drain && w_last_k;

  // Core g owns rows r_row + g; both share the B column operand.
  for (genvar g = 0; g < 2; g++) begin : g_core
    logic [4:0] w_row;
    logic [7:0] w_a_addr;
    assign w_row       = r_row + 5'(g);
    assign w_row_ok[g] = (w_row < {1'b0, r_n});
    assign w_base[g]   = 8'(w_row) * 8'(r_n);
    assign w_a_addr    = w_base[g] + 8'(r_k);
    assign w_a[g]      = (w_row_ok[g] && ({1'b0, w_a_addr} + 9'd1 < r_cnt)) ?
                         r_mem_a[c_AW'(w_a_addr)] : '0;
    assign w_sum[g]    = ((r_k == 4'd0) ? '0 : r_acc[g]) + w_a[g] * w_b;
  end

  always_ff @(posedge clk) begin
    if (w_ld_we) begin
      if (w_ld_a) r_mem_a[c_AW'(r_cnt - 9'd1)] <= com_data_in;
      else        r_mem_b[c_AW'(r_cnt - 9'd1 - {1'b0, w_nn})] <= com_data_in;
    end
    if (w_c_we) r_mem_c[c_AW'(w_base[0] + 8'(r_col))] <= w_sum[0];
    if (w_c_we && w_row_ok[1]) r_mem_c[c_AW'(w_base[1] + 8'(r_col))] <= w_sum[1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_dout   <= '0;
      r_ostart <= 1'b0;
      r_odone  <= 1'b0;
      r_cnt    <= '0;
      r_n      <= '0;
      r_acc[0] <= '0;
      r_acc[1] <= '0;
      r_err    <= 1'b0;
      r_drain  <= 1'b0;
      r_row    <= '0;
      r_col    <= '0;
      r_k      <= '0;
      r_oidx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (data_write_start) begin
            r_state <= LOAD;
            r_cnt   <= '0;
            r_n     <= '0;
            r_err   <= 1'b0;
          end
        end
        LOAD: begin
          if (data_write_done) begin
            r_row   <= '0;
            r_col   <= '0;
            r_k     <= '0;
            r_drain <= 1'b0;
            r_oidx  <= '0;
            if ((r_cnt == 9'd0) || !w_n_ok) begin
              r_state  <= OUTPUT;
              r_err    <= 1'b1;
              r_dout   <= '1;
              r_ostart <= 1'b1;
              r_odone  <= 1'b1;
            end else begin
              r_state <= COMPUTE;
            end
          end else if (w_first) begin
            r_n   <= com_data_in[3:0];
            r_cnt <= 9'd1;
          end else if (w_ld_we) begin
            r_cnt <= r_cnt + 9'd1;
          end
        end
        COMPUTE: begin
          // One extra cycle lets the last C write land before it is read out.
          if (r_drain) begin
            r_state  <= OUTPUT;
            r_dout   <= r_mem_c[c_AW'(0)];
            r_ostart <= 1'b1;
            r_odone  <= (w_nn == 8'd1);
            r_oidx   <= 8'd1;
          end else begin
            r_acc[0] <= w_sum[0];
            r_acc[1] <= w_sum[1];
            if (w_last_k) begin
              r_k <= '0;
              if (w_last_col) begin
                r_col <= '0;
                r_row <= r_row + 5'd2;
                if (w_last_row) r_drain <= 1'b1;
              end else begin
                r_col <= r_col + 4'd1;
              end
            end else begin
              r_k <= r_k + 4'd1;
            end
          end
        end
        OUTPUT: begin
          if (r_err || (r_oidx == w_nn)) begin
            r_state  <= IDLE;
            r_dout   <= '0;
            r_ostart <= 1'b0;
            r_odone  <= 1'b0;
          end else begin
            r_dout  <= r_mem_c[c_AW'(r_oidx)];
            r_odone <= (r_oidx == w_nn - 8'd1);
            r_oidx  <= r_oidx + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign state              = r_state;
  assign com_data_out       = r_dout;
  assign output_write_start = r_ostart;
  assign output_write_done  = r_odone;

endmodule
`default_nettype wire

// File: tb/tb_main_top.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_main_top : directed checks of main_top against a matrix-product model  |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_main_top;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] com_data_in;
  logic        data_write_start;
  logic        data_write_done;
  logic [1:0]  state;
  logic [15:0] com_data_out;
  logic        output_write_start;
  logic        output_write_done;

  main_top #(.DATA_W(16), .MAX_N(8)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .com_data_in        (com_data_in),
    .data_write_start   (data_write_start),
    .data_write_done    (data_write_done),
    .state              (state),
    .com_data_out       (com_data_out),
    .output_write_start (output_write_start),
    .output_write_done  (output_write_done)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_q   [$];
  logic [15:0] got_q   [$];
  logic [15:0] model_q [$];
  bit          saw_compute = 1'b0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_q(input string name, input logic [15:0] act[$], input logic [15:0] exp[$]);
    check({name, "_len"}, act.size(), exp.size());
    for (int i = 0; i < exp.size() && i < act.size(); i++)
      check($sformatf("%s[%0d]", name, i), act[i], exp[i]);
  endtask

  // Reference: C = A x B mod 2^16, missing operands are zero, bad N yields FFFF.
  task automatic build_model(input logic [15:0] w[$]);
    int          n;
    int          nn;
    int unsigned a [64];
    int unsigned b [64];
    int unsigned acc;
    model_q.delete();
    n = (w.size() > 0) ? int'(w[0][3:0]) : 0;
    if (n == 0 || n > 8) begin
      model_q.push_back(16'hFFFF);
    end else begin
      nn = n * n;
      for (int i = 0; i < nn; i++) begin
        a[i] = (1 + i < w.size()) ? int'(w[1 + i]) : 0;
        b[i] = (1 + nn + i < w.size()) ? int'(w[1 + nn + i]) : 0;
      end
      for (int r = 0; r < n; r++)
        for (int c = 0; c < n; c++) begin
          acc = 0;
          for (int k = 0; k < n; k++) acc += a[r * n + k] * b[k * n + c];
          model_q.push_back(16'(acc));
        end
    end
    exp_q = model_q;
    got_q.delete();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (state == 2'b10) saw_compute = 1'b1;
      if (output_write_start === 1'b1) begin
        got_q.push_back(com_data_out);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_word: got %0d expected no output", com_data_out);
        end else begin
          check("out_word", com_data_out, exp_q.pop_front());
          check("out_done", output_write_done, exp_q.size() == 0);
        end
      end else begin
        check("quiet_data", com_data_out, 0);
        check("quiet_done", output_write_done, 0);
      end
    end
  end

  // Entered and left just after a rising edge.
  task automatic load_txn(input logic [15:0] w[$]);
    build_model(w);
    saw_compute      = 1'b0;
    data_write_start = 1'b1;
    com_data_in      = 16'h0;
    foreach (w[i]) begin
      @(posedge clk); #1;
      com_data_in = w[i];
    end
    @(posedge clk); #1;
    data_write_done = 1'b1;
    com_data_in     = 16'hDEAD;
    @(posedge clk); #1;
    data_write_done  = 1'b0;
    data_write_start = 1'b0;
    com_data_in      = 16'h0;
  endtask

  task automatic finish_txn(input string name, input int budget, output int lat);
    int cyc = 0;
    lat = -1;
    while (output_write_done !== 1'b1 && cyc < budget) begin
      if (lat < 0 && output_write_start === 1'b1) lat = cyc;
      @(posedge clk); #1;
      cyc++;
    end
    if (lat < 0 && output_write_start === 1'b1) lat = cyc;
    if (output_write_done !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: no final word after %0d cycles", name, budget);
    end
    @(posedge clk); #1;
    check({name, "_back_to_idle"}, state, 0);
    check({name, "_words_left"}, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] w   [$];
    logic [15:0] lit [$];
    int          lat;

    rst_n            = 1'b0;
    data_write_start = 1'b0;
    data_write_done  = 1'b0;
    com_data_in      = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", state, 0);
    check("rst_data", com_data_out, 0);
    check("rst_start", output_write_start, 0);
    check("rst_done", output_write_done, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // 2x2 basic product
    w = '{16'd2, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    lit = '{16'd19, 16'd22, 16'd43, 16'd50};
    load_txn(w);
    check_q("model_n2", model_q, lit);
    finish_txn("n2", 50, lat);
    check_q("dut_n2", got_q, lit);
    check("n2_saw_compute", saw_compute, 1);

    // 1x1 with product wrap
    w = '{16'd1, 16'd300, 16'd300};
    lit = '{16'd24464};
    load_txn(w);
    check_q("model_n1", model_q, lit);
    finish_txn("n1", 50, lat);
    check_q("dut_n1", got_q, lit);

    // N = 0
    w = '{16'd0};
    lit = '{16'hFFFF};
    load_txn(w);
    finish_txn("n0", 50, lat);
    check_q("dut_n0", got_q, lit);
    check("n0_saw_compute", saw_compute, 0);
    check("n0_latency", lat, 0);

    // A only, B never loaded
    w = '{16'd2, 16'd1, 16'd2, 16'd3, 16'd4};
    lit = '{16'd0, 16'd0, 16'd0, 16'd0};
    load_txn(w);
    check_q("model_aonly", model_q, lit);
    finish_txn("aonly", 50, lat);
    check_q("dut_aonly", got_q, lit);

    // done before word 0
    w.delete();
    lit = '{16'hFFFF};
    load_txn(w);
    finish_txn("noword", 50, lat);
    check_q("dut_noword", got_q, lit);
    check("noword_saw_compute", saw_compute, 0);

    // N above MAX_N
    w = '{16'd9, 16'd1, 16'd2, 16'd3};
    load_txn(w);
    finish_txn("n9", 50, lat);
    check_q("dut_n9", got_q, lit);

    // 1x1 with surplus words that must be dropped
    w = '{16'd1, 16'd3, 16'd5, 16'd7, 16'd9};
    lit = '{16'd15};
    load_txn(w);
    finish_txn("surplus", 50, lat);
    check_q("dut_surplus", got_q, lit);

    // 3x3 odd size, wrapping sums, two surplus words
    w = '{16'd3};
    for (int i = 0; i < 9; i++) w.push_back(16'(i + 1));
    for (int i = 0; i < 9; i++) w.push_back(16'(16'hF000 + i * 16'h0123));
    w.push_back(16'h5555);
    w.push_back(16'hAAAA);
    load_txn(w);
    finish_txn("n3", 80, lat);
    check("n3_word_count", got_q.size(), 9);

    // reset in the middle of COMPUTE
    w = '{16'd2, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    load_txn(w);
    @(posedge clk); #1;
    check("midrst_in_compute", state, 2);
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_state", state, 0);
    check("midrst_data", com_data_out, 0);
    check("midrst_start", output_write_start, 0);
    check("midrst_done", output_write_done, 0);
    repeat (12) @(posedge clk);
    #1;
    check("midrst_still_idle", state, 0);
    lit = '{16'd19, 16'd22, 16'd43, 16'd50};
    load_txn(w);
    finish_txn("reload", 50, lat);
    check_q("dut_reload", got_q, lit);

    // 8x8 identity times index matrix
    w = '{16'd8};
    for (int i = 0; i < 64; i++) w.push_back((i / 8 == i % 8) ? 16'd1 : 16'd0);
    for (int i = 0; i < 64; i++) w.push_back(16'(i));
    lit.delete();
    for (int i = 0; i < 64; i++) lit.push_back(16'(i));
    load_txn(w);
    check_q("model_n8", model_q, lit);
    finish_txn("n8", 400, lat);
    check_q("dut_n8", got_q, lit);
    n_vec++;
    if (lat < 0 || lat > 260) begin
      n_err++;
      $display("FAIL n8_latency: got %0d cycles expected at most 260", lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
